// File: rtl/systolic_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_sequencer
//
// Drives the edge inputs of an N x N systolic multiply array. A start request
// clears the cell accumulators, streams k_len operand slices (column k of A,
// row k of B) out of external single-port memories, skews each lane so that
// matching operands meet in the right cell, waits for the wavefront to drain,
// and then pulses done.
//
// Optional feature: define SYSTOLIC_SEQ_PERF_EN to add the perf_cycles port,
// a saturating 16-bit count of busy cycles since reset.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-low
//   start        in   request a multiply (sampled only in IDLE)
//   k_len        in   inner dimension, latched with start, saturates at KMAX
//   a_col        in   column k of A, lane i at [i*W +: W], valid 1 cycle after rd_en
//   b_row        in   row k of B, same packing/latency
//   rd_en        out  operand memory read strobe
//   rd_addr      out  operand index k
//   a_edge       out  skewed A to array row inputs
//   b_edge       out  skewed B to array column inputs
//   array_clear  out  one-cycle accumulator clear
//   busy         out  high from CLEAR through DONE
//   done         out  one-cycle pulse, array results final
//   perf_cycles  out  busy-cycle count (SYSTOLIC_SEQ_PERF_EN only)
// -----------------------------------------------------------------------------
module systolic_sequencer #(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int KMAX = 16,
    localparam int AW   = $clog2(KMAX)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [AW:0]     k_len,
    input  logic [N*W-1:0]  a_col,
    input  logic [N*W-1:0]  b_row,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    output logic [N*W-1:0]  a_edge,
    output logic [N*W-1:0]  b_edge,
    output logic            array_clear,
    output logic            busy,
    output logic            done
`ifdef SYSTOLIC_SEQ_PERF_EN
    ,
    output logic [15:0]     perf_cycles
`endif
);

    localparam int KW = AW + 1;
    // Drain counter must hold 2N; it counts 2N..0, giving 2N+1 cycles.
    localparam int DW = $clog2(2 * N + 2);
    localparam logic [KW-1:0] KMAX_K     = KW'(KMAX);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(2 * N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   klen_q, klen_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            rd_vld_q;   // read data present on a_col/b_row this cycle
    logic            last_addr;

    // Only evaluated in FEED, where klen_q >= 1.
    assign last_addr = ({1'b0, addr_q} == (klen_q - KW'(1)));
    assign rd_addr   = addr_q;

    always_comb begin
        state_d     = state_q;
        klen_d      = klen_q;
        addr_d      = addr_q;
        drain_d     = drain_q;
        rd_en       = 1'b0;
        array_clear = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_CLEAR;
                    klen_d  = (k_len > KMAX_K) ? KMAX_K : k_len;
                end
            end
            S_CLEAR: begin
                array_clear = 1'b1;
                addr_d      = '0;
                drain_d     = DRAIN_LOAD;
                state_d     = (klen_q == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                rd_en = 1'b1;
                if (last_addr) begin
                    // Park the address at 0 so rd_addr is quiet outside FEED.
                    addr_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            klen_q   <= '0;
            addr_q   <= '0;
            drain_q  <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            klen_q   <= klen_d;
            addr_q   <= addr_d;
            drain_q  <= drain_d;
            rd_vld_q <= rd_en;
        end
    end

    // Per-lane skew: lane gi is a zero-filled shift register of depth gi+1.
    // Input is gated by rd_vld_q so bubbles push zeros into the array.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [W-1:0] a_sr_q [gi+1];
            logic [W-1:0] b_sr_q [gi+1];
            logic [W-1:0] a_in;
            logic [W-1:0] b_in;

            assign a_in = rd_vld_q ? a_col[gi*W +: W] : '0;
            assign b_in = rd_vld_q ? b_row[gi*W +: W] : '0;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    for (int j = 0; j <= gi; j++) begin
                        a_sr_q[j] <= '0;
                        b_sr_q[j] <= '0;
                    end
                end else begin
                    a_sr_q[0] <= a_in;
                    b_sr_q[0] <= b_in;
                    for (int j = 1; j <= gi; j++) begin
                        a_sr_q[j] <= a_sr_q[j-1];
                        b_sr_q[j] <= b_sr_q[j-1];
                    end
                end
            end

            assign a_edge[gi*W +: W] = a_sr_q[gi];
            assign b_edge[gi*W +: W] = b_sr_q[gi];
        end
    endgenerate

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
